// File: rtl/add_seq_ctrl.sv
// Word-serial multi-precision adder controller, LSB slice first.
// Define ADD_SEQ_SUB_EN to add the sub port (a - b via inverted b, carry-in 1).
module add_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   cin,
`ifdef ADD_SEQ_SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] s,
  output logic                   cout
);

  localparam int TW = WIDTH * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state, nxt;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [TW-1:0]   opa, opb, acc, acc_nx;
  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH:0]  sum;
  logic [TW-1:0]   b_in;
  logic            c_in;

`ifdef ADD_SEQ_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  always_comb begin
    sa     = opa[idx*WIDTH +: WIDTH];
    sb     = opb[idx*WIDTH +: WIDTH];
    sum    = {1'b0, sa} + {1'b0, sb}
           + {{WIDTH{1'b0}}, carry};
    acc_nx = acc;
    acc_nx[idx*WIDTH +: WIDTH] = sum[WIDTH-1:0];
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (idx == LAST) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx   <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      s     <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          idx <= '0;
          if (start) begin
            opa   <= a;
            opb   <= b_in;
            carry <= c_in;
            acc   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_nx;
          carry <= sum[WIDTH];
          idx   <= idx + IW'(1);
          // Publish only when the top slice lands
          if (idx == LAST) begin
            s    <= acc_nx;
            cout <= sum[WIDTH];
            idx  <= '0;
          end
        end
        DONE: idx <= '0;
        default: idx <= '0;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
